// File: rtl/dcache_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter_pkg
// Shared GPU memory definitions for the data-cache BRAM port arbiter.
//   - lane geometry of a data-cache row (8 lanes x 32 bits)
//   - full-row write mask used by host file-I/O writes
//   - arbiter FSM state encoding and enum
//   - lane_we(): converts a write flag plus lane mask into BRAM lane enables
// ---------------------------------------------------------------------------
package dcache_port_arbiter_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 32;
   localparam int LINE_W = LANES * LANE_W;

   localparam logic [LANES-1:0] FIO_FULL_MASK = 8'hFF;

   // Encodings kept as plain constants so legacy code can compare raw bits.
   localparam logic [1:0] ST_SHARED_ENC = 2'd0;
   localparam logic [1:0] ST_DRAIN_ENC  = 2'd1;
   localparam logic [1:0] ST_LOCKED_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_SHARED = ST_SHARED_ENC,
      ST_DRAIN  = ST_DRAIN_ENC,
      ST_LOCKED = ST_LOCKED_ENC
   } arb_state_e;

   // Reads never touch the array: a read yields an all-zero lane enable.
   function automatic logic [LANES-1:0] lane_we(input logic            we,
                                                input logic [LANES-1:0] mask);
      return we ? mask : '0;
   endfunction

endpackage

// File: rtl/dcache_port_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles in which a file-I/O request was denied.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   inc_i        : FIO was requesting and was denied this cycle
//   clr_i        : FIO was granted, idle, or arbiter not in SHARED
//   hit_o        : count has reached STARVE_MAX (force an FIO grant)
//   cnt_o        : current count (debug visibility)
// The count saturates at STARVE_MAX; clear wins over increment.
// ---------------------------------------------------------------------------
module starve_counter
#(
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_i,
   input  logic       clr_i,
   output logic       hit_o,
   output logic [3:0] cnt_o
);

   localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == MAX_C);
   assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter
// Arbitrates one external data-cache BRAM port between the memory pipeline
// (pipe_*) and the host file-I/O path (fio_*).
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   pipe_req/we/addr/wmask/wdata     : pipeline request (lane-masked writes)
//   pipe_ready, pipe_rvalid          : pipeline accept / read data valid
//   fio_req/we/addr/wdata            : host request (full-row writes)
//   fio_lock                         : host asks to own the port exclusively
//   fio_gnt, fio_rvalid, fio_locked  : host accept / read valid / owns port
//   bram_addr/we/wdata, bram_rdata   : shared BRAM port, 1-cycle read latency
//   rdata                            : bram_rdata, qualified by an rvalid
//   dbg_state, dbg_starve_cnt        : FSM state and starve count for debug
//
// Handshake: a request is taken in the cycle its ready/gnt is high; that
// cycle drives the BRAM. A granted read returns exactly one cycle later with
// the owner's rvalid high for that single cycle. At most one grant and at
// most one rvalid are ever high in a cycle.
//
// Policy: the pipeline wins in SHARED unless FIO has been denied STARVE_MAX
// cycles in a row. The cycle in which fio_lock is first seen in SHARED is
// the DRAIN cycle: nothing is granted, any pipe read from the previous cycle
// returns, and the next cycle is LOCKED. LOCKED serves only FIO and exits to
// SHARED the cycle after fio_lock drops.
// ---------------------------------------------------------------------------
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_req,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [LANES-1:0]  pipe_wmask,
   input  logic [LINE_W-1:0] pipe_wdata,
   output logic              pipe_ready,
   output logic              pipe_rvalid,
   input  logic              fio_req,
   input  logic              fio_we,
   input  logic [ADDR_W-1:0] fio_addr,
   input  logic [LINE_W-1:0] fio_wdata,
   input  logic              fio_lock,
   output logic              fio_gnt,
   output logic              fio_rvalid,
   output logic              fio_locked,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [LANES-1:0]  bram_we,
   output logic [LINE_W-1:0] bram_wdata,
   input  logic [LINE_W-1:0] bram_rdata,
   output logic [LINE_W-1:0] rdata,
   output logic [1:0]        dbg_state,
   output logic [3:0]        dbg_starve_cnt
);

   arb_state_e state_q;
   arb_state_e state_d;
   arb_state_e state_eff;

   logic       pipe_gnt;
   logic       fio_gnt_c;
   logic       locked_c;
   logic       starve_inc;
   logic       starve_hit;
   logic [3:0] starve_cnt;

   logic       rd_valid_q;
   logic       rd_valid_d;
   logic       rd_owner_q;   // 1 = FIO owns the read in flight
   logic       rd_owner_d;

   // Only SHARED and LOCKED are ever registered; DRAIN is the SHARED cycle
   // in which fio_lock is high, so pipe_ready drops the moment lock appears.
   always_comb begin
      state_eff = state_q;
      if (reset) begin
         state_eff = ST_SHARED;
      end else if ((state_q == ST_SHARED) && fio_lock) begin
         state_eff = ST_DRAIN;
      end
   end

   always_comb begin
      pipe_gnt  = 1'b0;
      fio_gnt_c = 1'b0;
      locked_c  = 1'b0;
      state_d   = state_q;
      if (!reset) begin
         unique case (state_eff)
            ST_SHARED: begin
               pipe_gnt  = pipe_req && !(fio_req && starve_hit);
               fio_gnt_c = fio_req && !pipe_gnt;
            end
            ST_DRAIN: begin
               state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
               locked_c  = 1'b1;
               fio_gnt_c = fio_req;
               if (!fio_lock) begin
                  state_d = ST_SHARED;
               end
            end
            default: begin
               state_d = ST_SHARED;
            end
         endcase
      end
   end

   // Counter is cleared whenever it should not increment, which also holds
   // it at zero through DRAIN and LOCKED.
   assign starve_inc = (state_eff == ST_SHARED) && !reset && fio_req && !fio_gnt_c;

   starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_counter (
      .clk   (clk),
      .reset (reset),
      .inc_i (starve_inc),
      .clr_i (!starve_inc),
      .hit_o (starve_hit),
      .cnt_o (starve_cnt)
   );

   assign rd_valid_d = (pipe_gnt && !pipe_we) || (fio_gnt_c && !fio_we);
   assign rd_owner_d = fio_gnt_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_SHARED;
         rd_valid_q <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   assign pipe_ready = pipe_gnt;
   assign fio_gnt    = fio_gnt_c;
   assign fio_locked = locked_c;

   // Gated by reset so a read in flight when reset asserts never returns.
   assign pipe_rvalid = !reset && rd_valid_q && !rd_owner_q;
   assign fio_rvalid  = !reset && rd_valid_q &&  rd_owner_q;

   assign bram_addr  = fio_gnt_c ? fio_addr  : pipe_addr;
   assign bram_wdata = fio_gnt_c ? fio_wdata : pipe_wdata;

   always_comb begin
      bram_we = '0;
      if (pipe_gnt) begin
         bram_we = lane_we(pipe_we, pipe_wmask);
      end else if (fio_gnt_c) begin
         bram_we = lane_we(fio_we, FIO_FULL_MASK);
      end
   end

   assign rdata          = bram_rdata;
   assign dbg_state      = state_eff;
   assign dbg_starve_cnt = starve_cnt;

endmodule
